// File: rtl/gf163_mul_seq.sv
// Control and storage side of the digit-serial GF(2^163) multiplier: latches A,
// streams B MSB digit first into the external PE array and returns T on a handshake.
module gf163_mul_seq #(
  parameter int            M      = 163,
  parameter int            D      = 32,
  parameter int            ND     = 6,
  parameter logic [M-1:0]  G_POLY = 163'hC9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [M-1:0] op_a,
  input  logic [M-1:0] op_b,
  output logic [M-1:0] pe_a,
  output logic [M-1:0] pe_g,
  output logic [D-1:0] pe_b_digit,
  output logic [M-1:0] pe_t_cur,
  input  logic [M-1:0] pe_t_next,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [M-1:0] res_data,
  output logic         busy
);

  // state | meaning
  // IDLE  | waiting for an operand pair, op_ready high
  // RUN   | ND cycles, one B digit per cycle folded into T
  // DONE  | product held on res_data until res_ready
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int BW = ND * D;
  localparam int CW = $clog2(ND);
  localparam logic [CW-1:0] CNT_LAST = CW'(ND - 1);

  state_t          state;
  logic [M-1:0]    a_q;
  logic [M-1:0]    t_q;
  logic [BW-1:0]   b_sh;
  logic [CW-1:0]   cnt;

  assign pe_a       = a_q;
  assign pe_g       = G_POLY;
  assign pe_t_cur   = t_q;
  assign pe_b_digit = b_sh[BW-1 -: D];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      t_q       <= '0;
      b_sh      <= '0;
      cnt       <= '0;
      op_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            a_q      <= op_a;
            b_sh     <= {{(BW-M){1'b0}}, op_b};
            t_q      <= '0;
            cnt      <= '0;
            op_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          t_q  <= pe_t_next;
          b_sh <= b_sh << D;
          // Counter holds at its last value so it never exceeds ND-1.
          if (cnt == CNT_LAST) begin
            res_valid <= 1'b1;
            res_data  <= pe_t_next;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
